// File: rtl/fp16_product_fixup_serializer.sv
// rtl/fp16_product_fixup_serializer.sv - FP16 product special-case/range fix-up with two-byte serializer
//
// Purpose: final stage of the log-domain binary16 multiplier. Captures the raw
//   product fields with the original operands, resolves NaN/inf/zero/overflow/
//   underflow into a binary16 result, then streams it low byte first.
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready          product handshake; in_ready only in IDLE
//   in_a, in_b                 original operands (binary16)
//   in_sign, in_exp, in_mant   product sign, signed 7-bit raw exponent, mantissa
//   out_byte/out_valid/out_ready/out_last   byte stream, out_last on the high byte
//   flag_nan/inf/ovf/unf       one-hot classification of the last result
//   res_count                  results fully sent, wrapping
// Config: define FP16_FIXUP_SAT_EN to saturate overflow to max finite instead of inf.
module fp16_product_fixup_serializer #(
  parameter logic [15:0] QNAN  = 16'h7E00,
  parameter int          CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_sign,
  input  logic [6:0]       in_exp,
  input  logic [9:0]       in_mant,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             flag_nan,
  output logic             flag_inf,
  output logic             flag_ovf,
  output logic             flag_unf,
  output logic [CNT_W-1:0] res_count
);

  typedef enum logic [1:0] {IDLE, CLASSIFY, SEND_LO, SEND_HI} state_t;

  state_t state, state_nxt;

  logic [15:0] a_q, b_q;
  logic        sign_q;
  logic [6:0]  exp_q;
  logic [9:0]  mant_q;
  logic [15:0] res_q;

  logic        load, commit, sent;

  // Operand classification on the captured copies
  logic a_exp_max, b_exp_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic exp_ovf, exp_unf;

  assign a_exp_max = (a_q[14:10] == 5'h1F);
  assign b_exp_max = (b_q[14:10] == 5'h1F);
  assign a_zero    = (a_q[14:10] == 5'h00);
  assign b_zero    = (b_q[14:10] == 5'h00);
  assign a_nan     = a_exp_max && (a_q[9:0] != 10'h0);
  assign b_nan     = b_exp_max && (b_q[9:0] != 10'h0);
  assign a_inf     = a_exp_max && (a_q[9:0] == 10'h0);
  assign b_inf     = b_exp_max && (b_q[9:0] == 10'h0);

  // The raw exponent is signed; its upper bits only matter for these range tests.
  assign exp_ovf   = ($signed(exp_q) >= 7'sd31);
  assign exp_unf   = ($signed(exp_q) <= 7'sd0);

  logic [15:0] res_c;
  logic        nan_c, inf_c, ovf_c, unf_c;

  always_comb begin
    res_c = {sign_q, 15'h0000};
    nan_c = 1'b0;
    inf_c = 1'b0;
    ovf_c = 1'b0;
    unf_c = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res_c = QNAN;
      nan_c = 1'b1;
    end else if (a_inf || b_inf) begin
      res_c = {sign_q, 5'h1F, 10'h000};
      inf_c = 1'b1;
    end else if (a_zero || b_zero) begin
      // Subnormal operands are flushed, so the product is a signed zero.
      res_c = {sign_q, 15'h0000};
    end else if (exp_ovf) begin
      ovf_c = 1'b1;
`ifdef FP16_FIXUP_SAT_EN
      res_c = {sign_q, 15'h7BFF};
`else
      res_c = {sign_q, 5'h1F, 10'h000};
`endif
    end else if (exp_unf) begin
      unf_c = 1'b1;
      res_c = {sign_q, 15'h0000};
    end else begin
      res_c = {sign_q, exp_q[4:0], mant_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stream outputs depend only on state and the registered result, so they stay
  // stable for as long as the consumer withholds out_ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_byte  = 8'h00;
    load      = 1'b0;
    commit    = 1'b0;
    sent      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = CLASSIFY;
        end
      end
      CLASSIFY: begin
        commit    = 1'b1;
        state_nxt = SEND_LO;
      end
      SEND_LO: begin
        out_valid = 1'b1;
        out_byte  = res_q[7:0];
        if (out_ready) begin
          state_nxt = SEND_HI;
        end
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_byte  = res_q[15:8];
        if (out_ready) begin
          sent      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      sign_q    <= 1'b0;
      exp_q     <= 7'h00;
      mant_q    <= 10'h000;
      res_q     <= 16'h0000;
      flag_nan  <= 1'b0;
      flag_inf  <= 1'b0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      res_count <= '0;
    end else begin
      if (load) begin
        a_q    <= in_a;
        b_q    <= in_b;
        sign_q <= in_sign;
        exp_q  <= in_exp;
        mant_q <= in_mant;
      end
      if (commit) begin
        res_q    <= res_c;
        flag_nan <= nan_c;
        flag_inf <= inf_c;
        flag_ovf <= ovf_c;
        flag_unf <= unf_c;
      end
      if (sent) begin
        res_count <= res_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp16_product_fixup_serializer.sv
// tb/tb_fp16_product_fixup_serializer.sv - randomized self-checking bench for fp16_product_fixup_serializer
module tb_fp16_product_fixup_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        in_sign;
  logic [6:0]  in_exp;
  logic [9:0]  in_mant;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        flag_nan, flag_inf, flag_ovf, flag_unf;
  logic [7:0]  res_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  fp16_product_fixup_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .flag_nan  (flag_nan),
    .flag_inf  (flag_inf),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .res_count (res_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: returns {nan,inf,ovf,unf, result[15:0]} computed from the fix-up rules.
  function automatic logic [19:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic s, input logic [6:0] e,
                                            input logic [9:0] m);
    int ea, eb, ma, mb, ex;
    bit a_nan, b_nan, a_inf, b_inf;
    logic [15:0] inf_v, zero_v, sat_v;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = int'(a[9:0]);
    mb = int'(b[9:0]);
    ex = int'(e);
    if (ex > 63) ex = ex - 128;
    a_nan  = (ea == 31) && (ma != 0);
    b_nan  = (eb == 31) && (mb != 0);
    a_inf  = (ea == 31) && (ma == 0);
    b_inf  = (eb == 31) && (mb == 0);
    inf_v  = s ? 16'hFC00 : 16'h7C00;
    zero_v = s ? 16'h8000 : 16'h0000;
    sat_v  = s ? 16'hFBFF : 16'h7BFF;
    if (a_nan || b_nan || (a_inf && eb == 0) || (b_inf && ea == 0)) return {4'b1000, 16'h7E00};
    if (a_inf || b_inf) return {4'b0100, inf_v};
    if (ea == 0 || eb == 0) return {4'b0000, zero_v};
`ifdef FP16_FIXUP_SAT_EN
    if (ex >= 31) return {4'b0010, sat_v};
`else
    if (ex >= 31) return {4'b0010, inf_v};
`endif
    if (ex <= 0) return {4'b0001, zero_v};
    return {4'b0000, 16'(int'(s) * 32768 + ex * 1024 + int'(m))};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    int k;
    v = 16'($urandom);
    k = $urandom_range(9);
    case (k)
      0: v[14:10] = 5'h00;
      1: v[14:0]  = 15'h7C00;
      2: begin
        v[14:10] = 5'h1F;
        if (v[9:0] == 10'h000) v[0] = 1'b1;
      end
      default: if (v[14:10] == 5'h00 || v[14:10] == 5'h1F) v[14:10] = 5'd15;
    endcase
    return v;
  endfunction

  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [6:0] e, input logic [9:0] m,
                         input int lo_stall, input int rdy_pct);
    logic [19:0] ref_v;
    logic [7:0]  bytes [2];
    logic        lasts [2];
    logic        held;
    logic [7:0]  held_byte;
    int          wait_c, got, stall_left;
    ref_v = ref_model(a, b, s, e, m);
    wait_c = 0;
    while (!in_ready && wait_c < 20) begin
      @(negedge clk);
      wait_c++;
    end
    check_eq("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_sign = s; in_exp = e; in_mant = m;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_exp = 7'($urandom); in_mant = 10'($urandom);
    check_eq("classify_no_valid", out_valid, 0);
    check_eq("busy_in_ready", in_ready, 0);
    @(negedge clk);
    check_eq("lo_latency", out_valid, 1);
    got = 0; held = 1'b0; held_byte = 8'h00; stall_left = lo_stall; wait_c = 0;
    bytes[0] = 8'h00; bytes[1] = 8'h00; lasts[0] = 1'b1; lasts[1] = 1'b0;
    while (got < 2 && wait_c < 200) begin
      if (held) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_byte", out_byte, held_byte);
        check_eq("hold_in_ready", in_ready, 0);
      end
      if (got == 0 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) < rdy_pct);
      end
      if (out_valid && out_ready) begin
        bytes[got] = out_byte;
        lasts[got] = out_last;
        got++;
        held = 1'b0;
      end else begin
        held      = out_valid;
        held_byte = out_byte;
      end
      @(negedge clk);
      wait_c++;
    end
    out_ready = 1'b0;
    check_eq("byte_count", got, 2);
    exp_cnt = (exp_cnt + 1) % 256;
    check_eq("lo_byte", bytes[0], ref_v[7:0]);
    check_eq("hi_byte", bytes[1], ref_v[15:8]);
    check_eq("lo_last", lasts[0], 0);
    check_eq("hi_last", lasts[1], 1);
    check_eq("idle_valid", out_valid, 0);
    check_eq("flags", {flag_nan, flag_inf, flag_ovf, flag_unf}, ref_v[19:16]);
    check_eq("res_count", res_count, exp_cnt);
    @(negedge clk);
    check_eq("flags_held", {flag_nan, flag_inf, flag_ovf, flag_unf}, ref_v[19:16]);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_c;
    rst = 1'b1; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_sign = 1'b0;
    in_exp = 7'h0; in_mant = 10'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_byte", out_byte, 0);
    check_eq("rst_flags", {flag_nan, flag_inf, flag_ovf, flag_unf}, 0);
    check_eq("rst_count", res_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, including the exponent range boundaries
    run_one(16'h3C00, 16'h4000, 1'b0, 7'd16, 10'h000, 0, 100);
    run_one(16'h7C00, 16'h0000, 1'b0, 7'd10, 10'h000, 0, 100);
    run_one(16'hFC00, 16'h3C00, 1'b1, 7'd15, 10'h000, 0, 100);
    run_one(16'h3C00, 16'h3C00, 1'b0, 7'd31, 10'h3FF, 0, 100);
    run_one(16'h3C00, 16'h3C00, 1'b1, 7'h7D, 10'h155, 0, 100);
    run_one(16'h3C00, 16'h3C00, 1'b0, 7'd30, 10'h3FF, 0, 100);
    run_one(16'h3C00, 16'h3C00, 1'b1, 7'd1,  10'h001, 0, 100);
    run_one(16'h3C00, 16'h3C00, 1'b0, 7'd0,  10'h2AA, 0, 100);
    run_one(16'h3C00, 16'h3C00, 1'b0, 7'h3F, 10'h000, 0, 100);
    run_one(16'h3C00, 16'h3C00, 1'b1, 7'h40, 10'h000, 0, 100);
    run_one(16'h7E01, 16'h3C00, 1'b0, 7'd16, 10'h000, 0, 100);
    run_one(16'h0200, 16'h4000, 1'b1, 7'd20, 10'h000, 0, 100);
    // Backpressure: hold the low byte for 5 cycles
    run_one(16'h3C00, 16'h4000, 1'b0, 7'd16, 10'h123, 5, 100);

    // Reset while the high byte is waiting
    wait_c = 0;
    while (!in_ready && wait_c < 20) begin @(negedge clk); wait_c++; end
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3C00; in_sign = 1'b0; in_exp = 7'd40; in_mant = 10'h0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("pre_rst_last", out_last, 1);
    check_eq("pre_rst_ovf", flag_ovf, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_flags", {flag_nan, flag_inf, flag_ovf, flag_unf}, 0);
    check_eq("mid_rst_count", res_count, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    run_one(16'h3C00, 16'h4000, 1'b0, 7'd16, 10'h0F0, 0, 100);

    // Randomized traffic with random backpressure; ends exactly at the counter wrap
    for (int i = 0; i < 255; i++) begin
      logic [6:0] e_r;
      if ($urandom_range(3) == 0) e_r = 7'($urandom);
      else e_r = 7'(int'($urandom_range(62)) - 15);
      run_one(rand_op(), rand_op(), 1'($urandom), e_r, 10'($urandom),
              int'($urandom_range(3)), 60);
    end
    check_eq("wrap_count", res_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
